// File: rtl/axi_decerr_responder.sv
// Default-slave AXI4 responder: completes every burst on unmapped addresses with DECERR
// and keeps a small debug log (last offending address, saturating hit counter).
module axi_decerr_responder #(
  parameter int unsigned AxiIdWidth   = 7,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [AxiDataWidth-1:0] RespData = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic                    w_last_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic                    err_o,
  output logic [AxiAddrWidth-1:0] err_addr_o,
  output logic [15:0]             err_cnt_o
);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DRAIN = 2'd1,
    W_RESP  = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  w_state_e                w_state_q, w_state_d;
  logic [AxiIdWidth-1:0]   b_id_q, b_id_d;
  r_state_e                r_state_q, r_state_d;
  logic [AxiIdWidth-1:0]   r_id_q, r_id_d;
  logic [7:0]              r_len_q, r_len_d;
  logic [7:0]              r_beat_q, r_beat_d;
  logic                    err_q, err_d;
  logic [AxiAddrWidth-1:0] err_addr_q, err_addr_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [16:0]             cnt_sum;
  logic                    aw_hs, ar_hs, r_last_beat;

  // Readies come from state only; reset masks them so nothing is accepted while held in reset.
  assign aw_ready_o  = rst_ni && (w_state_q == W_IDLE);
  assign ar_ready_o  = rst_ni && (r_state_q == R_IDLE);
  assign aw_hs       = aw_valid_i && aw_ready_o;
  assign ar_hs       = ar_valid_i && ar_ready_o;
  assign r_last_beat = (r_state_q == R_BURST) && (r_beat_q == r_len_q);

  assign w_ready_o  = (w_state_q == W_DRAIN);
  assign b_valid_o  = (w_state_q == W_RESP);
  assign b_id_o     = b_id_q;
  assign b_resp_o   = 2'b11;
  assign r_valid_o  = (r_state_q == R_BURST);
  assign r_id_o     = r_id_q;
  assign r_data_o   = RespData;
  assign r_resp_o   = 2'b11;
  assign r_last_o   = r_last_beat;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

  always_comb begin
    w_state_d = w_state_q;
    b_id_d    = b_id_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          b_id_d    = aw_id_i;
          w_state_d = W_DRAIN;
        end
      end
      W_DRAIN: begin
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_id_d    = ar_id_i;
          r_len_d   = ar_len_i;
          r_beat_d  = 8'd0;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        // The counter stops at len, so a 256-beat burst never needs to wrap.
        if (r_ready_i) begin
          if (r_last_beat) r_state_d = R_IDLE;
          else             r_beat_d  = r_beat_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    err_d      = aw_hs || ar_hs;
    err_addr_d = err_addr_q;
    if (aw_hs) err_addr_d = aw_addr_i;
    if (ar_hs) err_addr_d = ar_addr_i;
    cnt_sum   = {1'b0, err_cnt_q} + {16'd0, aw_hs} + {16'd0, ar_hs};
    err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      b_id_q     <= '0;
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_len_q    <= '0;
      r_beat_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      w_state_q  <= w_state_d;
      b_id_q     <= b_id_d;
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_len_q    <= r_len_d;
      r_beat_q   <= r_beat_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Bench for the DECERR responder: transaction-level model (open write, pending B,
// beats remaining) compared against every DUT output after each clock.
module tb_axi_decerr_responder;
  localparam int IW = 7;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] RESP = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int VW = 3 + IW + 2 + 2 + IW + DW + 2 + 1 + 1 + AW + 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [IW-1:0] aw_id_i = '0;
  logic [AW-1:0] aw_addr_i = '0;
  logic          aw_valid_i = 1'b0;
  logic          aw_ready_o;
  logic          w_last_i = 1'b0;
  logic          w_valid_i = 1'b0;
  logic          w_ready_o;
  logic [IW-1:0] b_id_o;
  logic [1:0]    b_resp_o;
  logic          b_valid_o;
  logic          b_ready_i = 1'b0;
  logic [IW-1:0] ar_id_i = '0;
  logic [AW-1:0] ar_addr_i = '0;
  logic [7:0]    ar_len_i = '0;
  logic          ar_valid_i = 1'b0;
  logic          ar_ready_o;
  logic [IW-1:0] r_id_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic          r_valid_o;
  logic          r_ready_i = 1'b0;
  logic          err_o;
  logic [AW-1:0] err_addr_o;
  logic [15:0]   err_cnt_o;

  always #5 clk_i = ~clk_i;

  axi_decerr_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_last_i(w_last_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_valid_i(ar_valid_i),
    .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a write is "open" between AW and the last W, then one B is owed.
  bit            m_wr_open, m_b_pend, m_err;
  logic [IW-1:0] m_b_id, m_r_id;
  int            m_r_left, m_cnt;
  logic [AW-1:0] m_err_addr;

  function automatic logic [VW-1:0] observed();
    return {aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o, ar_ready_o, r_valid_o,
            r_id_o, r_data_o, r_resp_o, r_last_o, err_o, err_addr_o, err_cnt_o};
  endfunction

  function automatic logic [VW-1:0] expected();
    logic [15:0] c;
    logic aw_rdy, ar_rdy;
    c = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    aw_rdy = rst_ni && !m_wr_open && !m_b_pend;
    ar_rdy = rst_ni && (m_r_left == 0);
    return {aw_rdy, m_wr_open, m_b_pend, m_b_id, 2'b11, ar_rdy, (m_r_left != 0),
            m_r_id, RESP, 2'b11, (m_r_left == 1), m_err, m_err_addr, c};
  endfunction

  task automatic model_reset();
    m_wr_open = 0; m_b_pend = 0; m_err = 0; m_b_id = '0; m_r_id = '0;
    m_r_left = 0; m_cnt = 0; m_err_addr = '0;
  endtask

  // One clock: evaluate handshakes from the model's view, advance DUT and model, settle.
  task automatic step();
    logic aw_h, w_h, wl, b_h, ar_h, r_h, rst;
    logic [IW-1:0] awid, arid;
    logic [AW-1:0] awa, ara;
    logic [7:0] len;
    rst  = rst_ni;
    aw_h = rst && aw_valid_i && !m_wr_open && !m_b_pend;
    w_h  = w_valid_i && m_wr_open;
    wl   = w_last_i;
    b_h  = b_ready_i && m_b_pend;
    ar_h = rst && ar_valid_i && (m_r_left == 0);
    r_h  = r_ready_i && (m_r_left != 0);
    awid = aw_id_i; awa = aw_addr_i; arid = ar_id_i; ara = ar_addr_i; len = ar_len_i;
    @(posedge clk_i);
    if (!rst) begin
      model_reset();
    end else begin
      if (b_h) m_b_pend = 0;
      if (w_h && wl) begin m_wr_open = 0; m_b_pend = 1; end
      if (aw_h) begin m_wr_open = 1; m_b_id = awid; end
      if (r_h) m_r_left--;
      if (ar_h) begin m_r_left = int'(len) + 1; m_r_id = arid; end
      m_err = aw_h || ar_h;
      if (aw_h) m_err_addr = awa;
      if (ar_h) m_err_addr = ara;
      m_cnt += int'(aw_h) + int'(ar_h);
    end
    #1;
  endtask

  task automatic drive_idle();
    aw_valid_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 0; ar_valid_i = 0; r_ready_i = 0;
  endtask

  task automatic test_reset();
    model_reset();
    drive_idle();
    rst_ni = 0;
    step(); step();
    vectors++;
    if (observed() !== expected()) begin
      miscompares++; $display("FAIL reset_held: got %h want %h", observed(), expected());
    end
    rst_ni = 1;
    step();
    vectors++;
    if ({aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, err_o, err_cnt_o} !== {6'b110000, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_release: got %b %b %b %b %b %b %h want 1 1 0 0 0 0 0000",
               aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, err_o, err_cnt_o);
    end
  endtask

  task automatic test_write_basic();
    aw_valid_i = 1; aw_id_i = 7'h05; aw_addr_i = 64'h5000_0000;
    step();
    aw_valid_i = 0;
    vectors++;
    if (observed() !== expected() || w_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL write_aw: got %h want %h", observed(), expected());
    end
    w_valid_i = 1;
    for (int b = 1; b <= 4; b++) begin
      w_last_i = (b == 4);
      step();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++; $display("FAIL write_beat%0d: got %h want %h", b, observed(), expected());
      end
    end
    w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
    vectors++;
    if ({b_valid_o, b_id_o, b_resp_o, err_cnt_o, err_addr_o} !== {1'b1, 7'h05, 2'b11, 16'd1, 64'h5000_0000}) begin
      miscompares++;
      $display("FAIL write_b: got v=%b id=%h resp=%b cnt=%0d addr=%h want v=1 id=05 resp=11 cnt=1 addr=50000000",
               b_valid_o, b_id_o, b_resp_o, err_cnt_o, err_addr_o);
    end
    step();
    b_ready_i = 0;
    vectors++;
    if (observed() !== expected() || b_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL write_done: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_read_stall();
    int beats = 0;
    ar_valid_i = 1; ar_id_i = 7'h12; ar_len_i = 8'd3; ar_addr_i = {$urandom, $urandom};
    step();
    ar_valid_i = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      r_ready_i = (c[0] == 1'b0);
      if (r_valid_o && r_ready_i) begin
        beats++;
        vectors++;
        if ({r_last_o, r_data_o, r_resp_o, r_id_o} !== {(beats == 4), RESP, 2'b11, 7'h12}) begin
          miscompares++;
          $display("FAIL read_beat%0d: got last=%b data=%h resp=%b id=%h want last=%b data=%h resp=11 id=12",
                   beats, r_last_o, r_data_o, r_resp_o, r_id_o, (beats == 4), RESP);
        end
      end
      step();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++; $display("FAIL read_stall cyc%0d: got %h want %h", c, observed(), expected());
      end
    end
    r_ready_i = 0;
    vectors++;
    if (beats != 4 || r_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL read_count: got %0d beats rvalid=%b want 4 beats rvalid=0", beats, r_valid_o);
    end
  endtask

  task automatic test_w_before_aw();
    w_valid_i = 1; w_last_i = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (w_ready_o !== 1'b0 || observed() !== expected()) begin
        miscompares++; $display("FAIL early_w cyc%0d: got wready=%b want 0", c, w_ready_o);
      end
    end
    aw_valid_i = 1; aw_id_i = 7'($urandom); aw_addr_i = {$urandom, $urandom};
    step();
    aw_valid_i = 0;
    vectors++;
    if (w_ready_o !== 1'b1 || observed() !== expected()) begin
      miscompares++; $display("FAIL early_w_after_aw: got wready=%b want 1", w_ready_o);
    end
    step();
    w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
    vectors++;
    if (b_valid_o !== 1'b1 || observed() !== expected()) begin
      miscompares++; $display("FAIL early_w_b: got bvalid=%b want 1", b_valid_o);
    end
    step();
    b_ready_i = 0;
    step();
    vectors++;
    if (b_valid_o !== 1'b0 || observed() !== expected()) begin
      miscompares++; $display("FAIL early_w_one_b: got bvalid=%b want 0", b_valid_o);
    end
  endtask

  task automatic test_simultaneous();
    int c0 = m_cnt;
    aw_valid_i = 1; aw_id_i = 7'h21; aw_addr_i = 64'h6000_0000;
    ar_valid_i = 1; ar_id_i = 7'h33; ar_addr_i = 64'h7000_0000; ar_len_i = 8'd0;
    step();
    aw_valid_i = 0; ar_valid_i = 0;
    vectors++;
    if ({err_o, err_cnt_o, err_addr_o} !== {1'b1, 16'(c0 + 2), 64'h7000_0000}) begin
      miscompares++;
      $display("FAIL simul_log: got err=%b cnt=%0d addr=%h want err=1 cnt=%0d addr=70000000",
               err_o, err_cnt_o, err_addr_o, c0 + 2);
    end
    w_valid_i = 1; w_last_i = 1; r_ready_i = 1; b_ready_i = 1;
    step();
    w_valid_i = 0; w_last_i = 0; r_ready_i = 0;
    vectors++;
    if (err_o !== 1'b0 || observed() !== expected()) begin
      miscompares++; $display("FAIL simul_pulse: got %h want %h", observed(), expected());
    end
    step();
    b_ready_i = 0;
    vectors++;
    if ({aw_ready_o, ar_ready_o, b_valid_o, r_valid_o} !== 4'b1100 || observed() !== expected()) begin
      miscompares++; $display("FAIL simul_done: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_long_read();
    int beats = 0;
    ar_valid_i = 1; ar_id_i = 7'h7F; ar_len_i = 8'd255; ar_addr_i = {$urandom, $urandom};
    step();
    ar_valid_i = 0; r_ready_i = 1;
    for (int c = 0; c < 300 && beats < 256; c++) begin
      if (r_valid_o) begin
        beats++;
        if (r_last_o !== (beats == 256)) begin
          miscompares++; $display("FAIL long_last beat%0d: got %b want %b", beats, r_last_o, (beats == 256));
        end
      end
      step();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++; $display("FAIL long_read cyc%0d: got %h want %h", c, observed(), expected());
      end
    end
    r_ready_i = 0;
    vectors++;
    if (beats != 256 || ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL long_count: got %0d beats arready=%b want 256 beats arready=1", beats, ar_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    ar_valid_i = 1; ar_id_i = 7'h0C; ar_len_i = 8'd7; ar_addr_i = {$urandom, $urandom};
    step();
    ar_valid_i = 0; r_ready_i = 1;
    step();
    rst_ni = 0;
    step();
    vectors++;
    if (r_valid_o !== 1'b0 || observed() !== expected()) begin
      miscompares++; $display("FAIL mid_reset: got rvalid=%b want 0", r_valid_o);
    end
    rst_ni = 1; r_ready_i = 0;
    ar_valid_i = 1; ar_id_i = 7'h0D; ar_len_i = 8'd0; ar_addr_i = 64'h5000_1000;
    step();
    ar_valid_i = 0;
    vectors++;
    if ({err_o, err_cnt_o, r_valid_o, r_id_o} !== {1'b1, 16'd1, 1'b1, 7'h0D}) begin
      miscompares++;
      $display("FAIL mid_reset_restart: got err=%b cnt=%0d rvalid=%b id=%h want 1 1 1 0d",
               err_o, err_cnt_o, r_valid_o, r_id_o);
    end
    r_ready_i = 1;
    step();
    r_ready_i = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_ni     = ($urandom_range(0, 199) != 0);
      aw_valid_i = $urandom_range(0, 1);
      aw_id_i    = 7'($urandom);
      aw_addr_i  = {$urandom, $urandom};
      w_valid_i  = $urandom_range(0, 1);
      w_last_i   = ($urandom_range(0, 2) == 0);
      b_ready_i  = $urandom_range(0, 1);
      ar_valid_i = $urandom_range(0, 1);
      ar_id_i    = 7'($urandom);
      ar_addr_i  = {$urandom, $urandom};
      ar_len_i   = ($urandom_range(0, 20) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      r_ready_i  = $urandom_range(0, 1);
      step();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++; $display("FAIL random cyc%0d: got %h want %h", c, observed(), expected());
      end
    end
    rst_ni = 1;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_stall();
    test_w_before_aw();
    test_simultaneous();
    test_long_read();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
